// File: rtl/spi_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_adc_pkg
// Brief   : Shared state encoding and frame-length helper for the SPI ADC master.
// Revision: 1.0  initial release
// ============================================================================
package spi_adc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_QUIET = 2'd2
   } state_e;

   function automatic int frame_bits(input int lead, input int data);
      return lead + data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_adc_sck_gen.sv
`default_nettype none
// ============================================================================
// Module  : spi_adc_sck_gen
// Brief   : SCK divider; strobes flag the clk edge that will raise/lower SCK.
// Revision: 1.0  initial release
// ============================================================================
module spi_adc_sck_gen #(
   parameter int CLK_DIV = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   output logic sck_o,
   output logic rise_stb_o,
   output logic fall_stb_o
);

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sck_q, sck_d;
   logic             div_end;

   assign div_end = (div_q == DIV_LAST);

   always_comb begin
      div_d = div_q;
      sck_d = sck_q;
      if (clr_i) begin
         div_d = '0;
         sck_d = 1'b0;
      end else if (div_end) begin
         div_d = '0;
         sck_d = ~sck_q;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         sck_q <= 1'b0;
      end else begin
         div_q <= div_d;
         sck_q <= sck_d;
      end
   end

   assign sck_o      = sck_q;
   assign rise_stb_o = ~clr_i & div_end & ~sck_q;
   assign fall_stb_o = ~clr_i & div_end &  sck_q;

endmodule
`default_nettype wire

// File: rtl/spi_adc_multi.sv
`default_nettype none
// ============================================================================
// Module  : spi_adc_multi
// Brief   : SPI master for simultaneous-sampling ADCs, NUM_CH MISO lanes, valid/ack output.
// Revision: 1.0  initial release
// ============================================================================
module spi_adc_multi
   import spi_adc_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 12,
   parameter int LEAD_BITS = 4,
   parameter int CLK_DIV   = 3,
   parameter int QUIET_CYC = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en_i,
   input  logic                     cont_i,
   input  logic                     start_i,
   output logic                     spi_cs_no,
   output logic                     spi_sck_o,
   input  logic [NUM_CH-1:0]        spi_miso_i,
   output logic                     busy_o,
   output logic [NUM_CH*DATA_W-1:0] data_o,
   output logic                     data_update_o,
   output logic                     data_valid_o,
   input  logic                     data_ack_i,
   output logic                     overrun_o
);

   localparam int                FRAME_BITS = frame_bits(LEAD_BITS, DATA_W);
   localparam int                CNT_W      = $clog2(FRAME_BITS + 1);
   localparam int                QCNT_W     = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0]  CNT_LEAD   = CNT_W'(LEAD_BITS);
   localparam logic [QCNT_W-1:0] QCNT_LAST  = QCNT_W'(QUIET_CYC - 1);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
   logic [QCNT_W-1:0]        qcnt_q, qcnt_d;
   logic [NUM_CH*DATA_W-1:0] data_q, data_d;
   logic                     update_q, update_d;
   logic                     valid_q, valid_d;
   logic                     overrun_q, overrun_d;

   logic                     sck_clr;
   logic                     rise_stb;
   logic                     fall_stb;
   logic                     capture;
   logic                     frame_done;
   logic [NUM_CH*DATA_W-1:0] shift_all;

   // Divider only runs inside a frame, so every frame starts from a cleared phase.
   assign sck_clr = (state_q != ST_FRAME) | ~en_i;

   spi_adc_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (sck_clr),
      .sck_o      (spi_sck_o),
      .rise_stb_o (rise_stb),
      .fall_stb_o (fall_stb)
   );

   assign capture = rise_stb & (bit_cnt_q >= CNT_LEAD);

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         logic [DATA_W-1:0] shift_q, shift_d;

         always_comb begin
            shift_d = shift_q;
            if (capture) begin
               shift_d = DATA_W'({shift_q, spi_miso_i[c]});
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shift_q <= '0;
            end else begin
               shift_q <= shift_d;
            end
         end

         assign shift_all[c*DATA_W +: DATA_W] = shift_q;
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      qcnt_d     = qcnt_q;
      frame_done = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            bit_cnt_d = '0;
            if (cont_i | start_i) begin
               state_d = ST_FRAME;
            end
         end
         ST_FRAME: begin
            if (rise_stb) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            if (fall_stb && (bit_cnt_q == CNT_LAST)) begin
               frame_done = 1'b1;
               state_d    = ST_QUIET;
               qcnt_d     = '0;
            end
         end
         ST_QUIET: begin
            if (qcnt_q == QCNT_LAST) begin
               bit_cnt_d = '0;
               state_d   = cont_i ? ST_FRAME : ST_IDLE;
            end else begin
               qcnt_d = qcnt_q + QCNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (!en_i) begin
         state_d    = ST_IDLE;
         bit_cnt_d  = '0;
         frame_done = 1'b0;
      end
   end

   // A fresh result outranks a same-cycle ack; overrun only when the old one was never taken.
   always_comb begin
      data_d    = data_q;
      update_d  = frame_done;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (data_ack_i) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
      if (frame_done) begin
         data_d  = shift_all;
         valid_d = 1'b1;
         if (valid_q && !data_ack_i) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         qcnt_q    <= '0;
         data_q    <= '0;
         update_q  <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         qcnt_q    <= qcnt_d;
         data_q    <= data_d;
         update_q  <= update_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign spi_cs_no     = (state_q != ST_FRAME);
   assign busy_o        = (state_q != ST_IDLE);
   assign data_o        = data_q;
   assign data_update_o = update_q;
   assign data_valid_o  = valid_q;
   assign overrun_o     = overrun_q;

endmodule
`default_nettype wire
